// File: rtl/maze_carver_dfs.sv
// rtl/maze_carver_dfs.sv - randomized DFS maze carver (optional trace port via CARVE_TRACE_EN)
module maze_carver_dfs #(
    parameter int MAZE_W = 16,
    parameter int MAZE_H = 16,
    parameter int LFSR_W = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [LFSR_W-1:0]                     seed,
    input  logic [6:0]                            x_dimension,
    input  logic [6:0]                            y_dimension,
    output logic [MAZE_W*MAZE_H-1:0]              maze_data,
    output logic                                  busy,
    output logic                                  finish,
    output logic [$clog2(MAZE_W)-1:0]             curr_x,
    output logic [$clog2(MAZE_H)-1:0]             curr_y
`ifdef CARVE_TRACE_EN
    ,
    output logic                                  carve_valid,
    output logic [$clog2(MAZE_W*MAZE_H)-1:0]      carve_addr
`endif
);

    localparam int XW    = $clog2(MAZE_W);
    localparam int YW    = $clog2(MAZE_H);
    localparam int AW    = $clog2(MAZE_W*MAZE_H);
    localparam int NB    = MAZE_W*MAZE_H;
    localparam int DMAX  = ((MAZE_W-1)/2)*((MAZE_H-1)/2);
    localparam int SPW   = $clog2(DMAX+1);
    localparam int CAP_W = (MAZE_W % 2 == 1) ? MAZE_W : MAZE_W-1;
    localparam int CAP_H = (MAZE_H % 2 == 1) ? MAZE_H : MAZE_H-1;

    // Galois feedback masks for maximal-length sequences, right-shifting form
    localparam logic [63:0] TAPS64 = (LFSR_W == 8)  ? 64'h0000_00B8 :
                                     (LFSR_W == 24) ? 64'h00E1_0000 :
                                     (LFSR_W == 32) ? 64'hA300_0000 :
                                                      64'h0000_B400;
    localparam logic [LFSR_W-1:0] TAPS     = TAPS64[LFSR_W-1:0];
    localparam logic [63:0]       ALT64    = 64'h0000_ACE1;
    localparam logic [LFSR_W-1:0] ALT_SEED = ALT64[LFSR_W-1:0];

    localparam logic [AW-1:0] ORIGIN_IDX = AW'(MAZE_W + 1);
    localparam logic [NB-1:0] ORIGIN_MAP = {{(NB-1){1'b0}}, 1'b1} << (MAZE_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_CARVE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [LFSR_W-1:0]  lfsr, lfsr_next;
    logic [XW-1:0]      x_lim;
    logic [YW-1:0]      y_lim;
    logic [SPW-1:0]     sp, sp_dec;
    logic [XW+YW-1:0]   stack [DMAX];
    logic [XW+YW-1:0]   stack_top;
    logic [3:0]         mask;
    logic [1:0]         dir;
    logic [XW-1:0]      tgt_x, wall_x;
    logic [YW-1:0]      tgt_y, wall_y;
    logic [AW-1:0]      tgt_idx, wall_idx;
    logic               load, push, pop;

    // Clamp the requested size to an odd value between 5 and the largest odd bitmap size
    function automatic int legalise(input int req, input int cap);
        int v;
        v = (req < cap) ? req : cap;
        if (v % 2 == 0) v = v - 1;
        if (v < 5) v = 5;
        return v;
    endfunction

    assign lfsr_next = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
    assign sp_dec    = sp - SPW'(1);
    assign stack_top = stack[sp_dec];

    // Unvisited neighbours two cells away, bit order {right, down, left, up}
    always_comb begin
        int cx, cy, xl, yl;
        cx = int'(curr_x);
        cy = int'(curr_y);
        xl = int'(x_lim);
        yl = int'(y_lim);
        mask    = '0;
        mask[0] = (cy >= 3)      && !maze_data[AW'(cx + MAZE_W*(cy-2))];
        mask[1] = (cx >= 3)      && !maze_data[AW'(cx - 2 + MAZE_W*cy)];
        mask[2] = (cy + 2 <= yl) && !maze_data[AW'(cx + MAZE_W*(cy+2))];
        mask[3] = (cx + 2 <= xl) && !maze_data[AW'(cx + 2 + MAZE_W*cy)];
    end

    // Pick the first open direction scanning cyclically from the random index, then derive wall/target
    always_comb begin
        logic       found;
        logic [1:0] d;
        found = 1'b0;
        d     = '0;
        dir   = '0;
        for (int k = 0; k < 4; k++) begin
            d = lfsr[1:0] + 2'(k);
            if (!found && mask[d]) begin
                dir   = d;
                found = 1'b1;
            end
        end
        tgt_x  = curr_x;
        tgt_y  = curr_y;
        wall_x = curr_x;
        wall_y = curr_y;
        case (dir)
            2'd0: begin tgt_y = curr_y - YW'(2); wall_y = curr_y - YW'(1); end
            2'd1: begin tgt_x = curr_x - XW'(2); wall_x = curr_x - XW'(1); end
            2'd2: begin tgt_y = curr_y + YW'(2); wall_y = curr_y + YW'(1); end
            default: begin tgt_x = curr_x + XW'(2); wall_x = curr_x + XW'(1); end
        endcase
        tgt_idx  = AW'(int'(tgt_x)  + MAZE_W*int'(tgt_y));
        wall_idx = AW'(int'(wall_x) + MAZE_W*int'(wall_y));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next state, handshake outputs and step decode
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        finish     = 1'b0;
        load       = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy       = 1'b1;
                next_state = S_CARVE;
            end
            S_CARVE: begin
                busy = 1'b1;
                if (mask != 4'd0)  push = 1'b1;
                else if (sp != '0) pop  = 1'b1;
                else               next_state = S_DONE;
            end
            default: begin
                finish = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = S_CLEAR;
                end
            end
        endcase
    end

    // Bitmap, cursor, stack pointer, LFSR and latched dimensions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maze_data <= '0;
            curr_x    <= XW'(1);
            curr_y    <= YW'(1);
            sp        <= '0;
            lfsr      <= '0;
            x_lim     <= XW'(3);
            y_lim     <= YW'(3);
        end else begin
            if (load) begin
                lfsr  <= (seed == '0) ? ALT_SEED : seed;
                x_lim <= XW'(legalise(int'(x_dimension), CAP_W) - 2);
                y_lim <= YW'(legalise(int'(y_dimension), CAP_H) - 2);
            end else if (busy) begin
                lfsr <= lfsr_next;
            end
            if (state == S_CLEAR) begin
                maze_data <= ORIGIN_MAP;
                curr_x    <= XW'(1);
                curr_y    <= YW'(1);
                sp        <= '0;
            end
            if (push) begin
                maze_data[wall_idx] <= 1'b1;
                maze_data[tgt_idx]  <= 1'b1;
                curr_x              <= tgt_x;
                curr_y              <= tgt_y;
                sp                  <= sp + SPW'(1);
            end
            if (pop) begin
                curr_x <= stack_top[XW+YW-1:YW];
                curr_y <= stack_top[YW-1:0];
                sp     <= sp_dec;
            end
        end
    end

    // Backtrack stack storage; contents are meaningless while sp is zero so no reset
    always_ff @(posedge clk) begin
        if (push) stack[sp] <= {curr_x, curr_y};
    end

    // The stack can never exceed one entry per cell nor pop when empty
    always @(posedge clk) begin
        if (rst_n && push) assert (int'(sp) < DMAX);
        if (rst_n && pop)  assert (sp != '0);
    end

`ifdef CARVE_TRACE_EN
    logic          hold_valid;
    logic [AW-1:0] hold_addr;

    // Target of a push is reported one cycle after its wall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
        end else begin
            hold_valid <= push;
            if (push) hold_addr <= tgt_idx;
        end
    end

    // On back-to-back pushes the new wall wins; the dropped target is the new push's source cell
    always_comb begin
        carve_valid = 1'b0;
        carve_addr  = '0;
        if (state == S_CLEAR) begin
            carve_valid = 1'b1;
            carve_addr  = ORIGIN_IDX;
        end else if (push) begin
            carve_valid = 1'b1;
            carve_addr  = wall_idx;
        end else if (hold_valid) begin
            carve_valid = 1'b1;
            carve_addr  = hold_addr;
        end
    end
`endif

endmodule

// File: tb/tb_maze_carver_dfs.sv
// tb/tb_maze_carver_dfs.sv - self-checking bench for maze_carver_dfs
module tb_maze_carver_dfs;

    localparam int MW = 16;
    localparam int MH = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [15:0]     seed;
    logic [6:0]      x_dimension;
    logic [6:0]      y_dimension;
    logic [MW*MH-1:0] maze_data;
    logic            busy;
    logic            finish;
    logic [3:0]      curr_x;
    logic [3:0]      curr_y;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int n;
        int w;
        int h;
    } exp_t;

    exp_t sb[$];

    maze_carver_dfs #(.MAZE_W(MW), .MAZE_H(MH), .LFSR_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .seed(seed),
        .x_dimension(x_dimension),
        .y_dimension(y_dimension),
        .maze_data(maze_data),
        .busy(busy),
        .finish(finish),
        .curr_x(curr_x),
        .curr_y(curr_y)
    );

    always #5 clk = ~clk;

    // Structural properties of a bitmap: population, stray bits, illegal corner bits, flood fill from (1,1)
    task automatic analyze(input logic [MW*MH-1:0] m, input int w, input int h,
                           output int bits, output int outside, output int badpos,
                           output int reach_bits, output int reach_cells);
        bit seen [MW*MH];
        int q[$];
        int p, x, y;
        bits = 0; outside = 0; badpos = 0; reach_bits = 0; reach_cells = 0;
        for (int i = 0; i < MW*MH; i++) seen[i] = 1'b0;
        for (int yy = 0; yy < MH; yy++)
            for (int xx = 0; xx < MW; xx++)
                if (m[xx + MW*yy]) begin
                    bits++;
                    if (xx < 1 || xx > w-2 || yy < 1 || yy > h-2) outside++;
                    if (xx % 2 == 0 && yy % 2 == 0) badpos++;
                end
        if (m[1 + MW]) begin
            q.push_back(1 + MW);
            seen[1 + MW] = 1'b1;
        end
        while (q.size() > 0) begin
            p = q.pop_front();
            x = p % MW;
            y = p / MW;
            reach_bits++;
            if (x % 2 == 1 && y % 2 == 1) reach_cells++;
            if (x > 0      && m[p-1]  && !seen[p-1])  begin seen[p-1]  = 1'b1; q.push_back(p-1);  end
            if (x < MW-1   && m[p+1]  && !seen[p+1])  begin seen[p+1]  = 1'b1; q.push_back(p+1);  end
            if (y > 0      && m[p-MW] && !seen[p-MW]) begin seen[p-MW] = 1'b1; q.push_back(p-MW); end
            if (y < MH-1   && m[p+MW] && !seen[p+MW]) begin seen[p+MW] = 1'b1; q.push_back(p+MW); end
        end
    endtask

    // One generation: expectation queued at start, checked when finish rises
    task automatic run_maze(input int x, input int y, input logic [15:0] s,
                            input int ew, input int eh, input int mid,
                            output logic [MW*MH-1:0] m);
        exp_t e;
        int cycles, guard;
        int bits, outside, badpos, rbits, rcells;
        sb.push_back('{n: ((ew-1)/2)*((eh-1)/2), w: ew, h: eh});
        @(negedge clk);
        x_dimension = 7'(x);
        y_dimension = 7'(y);
        seed        = s;
        start       = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        guard  = 0;
        while (finish !== 1'b1 && guard < 4000) begin
            if (busy === 1'b1) cycles++;
            start = (mid != 0 && cycles == mid) ? 1'b1 : 1'b0;
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        m = maze_data;
        e = sb.pop_front();
        total++;
        if (finish !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_flags x=%0d y=%0d: busy=%b finish=%b, required busy=0 finish=1", x, y, busy, finish);
        end
        total++;
        if (cycles != 2*e.n) begin
            bad++;
            $display("FAIL busy_cycles x=%0d y=%0d: got %0d, required %0d", x, y, cycles, 2*e.n);
        end
        analyze(m, e.w, e.h, bits, outside, badpos, rbits, rcells);
        total++;
        if (bits != 2*e.n - 1) begin
            bad++;
            $display("FAIL path_bits x=%0d y=%0d: got %0d, required %0d", x, y, bits, 2*e.n-1);
        end
        total++;
        if (outside != 0 || badpos != 0) begin
            bad++;
            $display("FAIL region x=%0d y=%0d: stray=%0d corner=%0d, required 0 and 0", x, y, outside, badpos);
        end
        total++;
        if (rcells != e.n || rbits != bits) begin
            bad++;
            $display("FAIL connected x=%0d y=%0d: cells=%0d bits=%0d, required cells=%0d bits=%0d",
                     x, y, rcells, rbits, e.n, bits);
        end
        repeat (3) @(negedge clk);
        total++;
        if (maze_data !== m || finish !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_stable x=%0d y=%0d: finish=%b busy=%b changed=%b, required 1 0 0",
                     x, y, finish, busy, maze_data !== m);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        seed  = 16'h0;
        x_dimension = 7'd15;
        y_dimension = 7'd15;
        repeat (2) @(negedge clk);
        total++;
        if (maze_data !== '0 || busy !== 1'b0 || finish !== 1'b0 || curr_x !== 4'd1 || curr_y !== 4'd1) begin
            bad++;
            $display("FAIL reset_values: maze_zero=%b busy=%b finish=%b curr=(%0d,%0d), required 1 0 0 (1,1)",
                     maze_data === '0, busy, finish, curr_x, curr_y);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (maze_data !== '0 || busy !== 1'b0 || finish !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: maze_zero=%b busy=%b finish=%b, required 1 0 0",
                     maze_data === '0, busy, finish);
        end
    endtask

    task automatic test_minimal();
        logic [MW*MH-1:0] m;
        run_maze(5, 5, 16'h1234, 5, 5, 0, m);
        total++;
        if ({m[1+MW], m[3+MW], m[1+3*MW], m[3+3*MW]} !== 4'b1111) begin
            bad++;
            $display("FAIL min_cells: got %b, required 1111", {m[1+MW], m[3+MW], m[1+3*MW], m[3+3*MW]});
        end
    endtask

    task automatic test_full();
        logic [MW*MH-1:0] m;
        run_maze(15, 15, 16'h5A5A, 15, 15, 0, m);
        run_maze(127, 127, 16'h0F0F, 15, 15, 0, m);
    endtask

    task automatic test_determinism();
        logic [MW*MH-1:0] m1, m2, m3, m4, m5;
        run_maze(15, 15, 16'hBEEF, 15, 15, 0, m1);
        run_maze(15, 15, 16'hBEEF, 15, 15, 0, m2);
        total++;
        if (m1 !== m2) begin
            bad++;
            $display("FAIL repeat_seed: got %h, required %h", m2, m1);
        end
        run_maze(15, 15, 16'h0000, 15, 15, 0, m3);
        run_maze(15, 15, 16'hACE1, 15, 15, 0, m4);
        total++;
        if (m3 !== m4) begin
            bad++;
            $display("FAIL zero_seed: got %h, required %h", m3, m4);
        end
        run_maze(15, 15, 16'h0001, 15, 15, 0, m5);
        total++;
        if (m5 === m1) begin
            bad++;
            $display("FAIL seed_differs: got %h, required anything but %h", m5, m1);
        end
    endtask

    task automatic test_legalise();
        logic [MW*MH-1:0] m;
        run_maze(6, 127, 16'h2222, 5, 15, 0, m);
        run_maze(2, 5, 16'h3333, 5, 5, 0, m);
        run_maze(10, 3, 16'h4444, 9, 5, 0, m);
    endtask

    task automatic test_start_ignored();
        logic [MW*MH-1:0] m;
        run_maze(15, 15, 16'h7777, 15, 15, 20, m);
    endtask

    task automatic test_reset_mid();
        logic [MW*MH-1:0] m;
        @(negedge clk);
        x_dimension = 7'd15;
        y_dimension = 7'd15;
        seed        = 16'h9999;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy: got %b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (maze_data !== '0 || busy !== 1'b0 || finish !== 1'b0 || curr_x !== 4'd1 || curr_y !== 4'd1) begin
            bad++;
            $display("FAIL mid_reset: maze_zero=%b busy=%b finish=%b curr=(%0d,%0d), required 1 0 0 (1,1)",
                     maze_data === '0, busy, finish, curr_x, curr_y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_maze(9, 7, 16'h9999, 9, 7, 0, m);
    endtask

    task automatic test_back_to_back();
        logic [MW*MH-1:0] m;
        run_maze(7, 9, 16'hC0DE, 7, 9, 0, m);
        run_maze(13, 11, 16'hF00D, 13, 11, 0, m);
    endtask

    initial begin
        test_reset();
        test_minimal();
        test_full();
        test_determinism();
        test_legalise();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
